// File: rtl/conv1_relu_pool.sv
// conv1 post-processing: per-channel bias, arithmetic right shift, ReLU, 16-bit saturation, 2x2/stride-2 max-pool.
// Optional build macro CONV1_RQ_ROUND_EN: round-half-up before the shift instead of a pure floor shift.
module conv1_relu_pool #(
    parameter int COUT  = 4,
    parameter int H_OUT = 8,
    parameter int W_OUT = 8,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [COUT-1:0][ACC_W-1:0]  bias_i,
    input  logic [4:0]                  shift_i,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ACC_W-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_data,
    output logic                        busy,
    output logic                        done
);

    localparam int CW = (COUT > 1) ? $clog2(COUT) : 1;
    localparam int HW = (H_OUT > 1) ? $clog2(H_OUT) : 1;
    localparam int WW = (W_OUT > 1) ? $clog2(W_OUT) : 1;
    localparam int LN = W_OUT / 2;
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;
    localparam int SW = ACC_W + 2;

    localparam logic [CW-1:0]    C_LAST = CW'(COUT - 1);
    localparam logic [HW-1:0]    H_LAST = HW'(H_OUT - 1);
    localparam logic [WW-1:0]    W_LAST = WW'(W_OUT - 1);
    localparam logic [OUT_W-1:0] Q_MAX  = {1'b0, {(OUT_W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COUT-1:0][ACC_W-1:0] bias_q;
    logic [4:0]                 shift_q;
    logic [CW-1:0]              c_cnt;
    logic [HW-1:0]              h_cnt;
    logic [WW-1:0]              w_cnt;
    logic [OUT_W-1:0]           colreg;
    logic [OUT_W-1:0]           lb [LN];

    logic                       in_fire, out_fire, last_elem, emit;
    logic [ACC_W-1:0]           bias_sel;
    logic signed [SW-1:0]       sum, sum_r, shifted;
    logic [OUT_W-1:0]           q, pair_max, lb_rd, pool_max;
    logic [LW-1:0]              lb_idx;

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits for ready,
    // and once out_valid is raised it holds with out_data stable until out_ready.
    assign in_ready  = (state_q == S_RUN) && (!out_valid || out_ready);
    assign busy      = (state_q != S_IDLE);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_elem = (c_cnt == C_LAST) && (h_cnt == H_LAST) && (w_cnt == W_LAST);
    assign emit      = in_fire && w_cnt[0] && h_cnt[0];
    assign lb_idx    = LW'(w_cnt >> 1);

    // Requantize the element being accepted; two guard bits keep bias and rounding sums exact.
    always_comb begin
        bias_sel = bias_q[c_cnt];
        sum      = $signed({{2{in_data[ACC_W-1]}}, in_data})
                 + $signed({{2{bias_sel[ACC_W-1]}}, bias_sel});
`ifdef CONV1_RQ_ROUND_EN
        sum_r    = (shift_q != 5'd0) ? (sum + (SW'(1) << (shift_q - 5'd1))) : sum;
`else
        sum_r    = sum;
`endif
        shifted  = sum_r >>> shift_q;
        q        = '0;
        if (shifted[SW-1]) begin
            q = '0;
        end else if (|shifted[SW-2:OUT_W-1]) begin
            q = Q_MAX;
        end else begin
            q = shifted[OUT_W-1:0];
        end
        pair_max = (colreg > q) ? colreg : q;
        lb_rd    = lb[lb_idx];
        pool_max = (lb_rd > pair_max) ? lb_rd : pair_max;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)                state_d = S_RUN;
            S_RUN:   if (in_fire && last_elem) state_d = S_FLUSH;
            S_FLUSH: if (out_fire)             state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == S_FLUSH) && out_fire;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q  <= '0;
            shift_q <= '0;
            c_cnt   <= '0;
            h_cnt   <= '0;
            w_cnt   <= '0;
        end else if (state_q == S_IDLE && start) begin
            bias_q  <= bias_i;
            shift_q <= shift_i;
            c_cnt   <= '0;
            h_cnt   <= '0;
            w_cnt   <= '0;
        end else if (in_fire) begin
            if (w_cnt == W_LAST) begin
                w_cnt <= '0;
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    c_cnt <= (c_cnt == C_LAST) ? '0 : c_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end else begin
                w_cnt <= w_cnt + 1'b1;
            end
        end
    end

    // Even rows park column-pair maxima in lb; odd rows combine them into a pooled result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colreg    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < LN; i++) begin
                lb[i] <= '0;
            end
        end else begin
            if (in_fire) begin
                if (!w_cnt[0]) begin
                    colreg <= q;
                end else if (!h_cnt[0]) begin
                    lb[lb_idx] <= pair_max;
                end else begin
                    out_data <= pool_max;
                end
            end
            if (emit) begin
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/conv1_relu_pool.md
Name: conv1_relu_pool

Overview:
- Post-processing stage directly downstream of conv1_small_gemm_top.
- Consumes the conv1 32-bit accumulator stream in channel-major raster order (co, oh, ow), the same order as the golden out files.
- Per element: adds per-channel bias, arithmetic right shift, ReLU, saturates to 16 bits.
- Applies 2x2/stride-2 max-pool and streams pooled results to the next layer over valid/ready.

Parameters:
- COUT, 4, number of output channels / frames per run
- H_OUT, 8, conv output height; must be even
- W_OUT, 8, conv output width; must be even
- ACC_W, 32, accumulator input width
- OUT_W, 16, pooled output width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run; ignored unless IDLE
- bias_i  in  COUT x ACC_W  signed per-channel bias; sampled on start
- shift_i  in  5  right-shift amount 0..31; sampled on start
- in_valid  in  1  input element valid
- in_ready  out  1  input element accepted when in_valid && in_ready
- in_data  in  ACC_W  signed accumulator
- out_valid  out  1  pooled element valid
- out_ready  in  1  downstream ready
- out_data  out  OUT_W  pooled value, unsigned range 0..32767
- busy  out  1  high in RUN and FLUSH
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; counters, column register and line buffer cleared. in_ready=0, out_valid=0, out_data=0, busy=0, done=0. Reset asserted mid-run abandons the run; no done pulse.
- FSM states:
  - IDLE: on start, latch bias_i and shift_i, clear counters, go to RUN.
  - RUN: counters c/h/w advance on each input handshake, w fastest. On acceptance of element (COUT-1, H_OUT-1, W_OUT-1), go to FLUSH.
  - FLUSH: wait for the final out handshake, then go to IDLE with done=1 for exactly that next cycle.
  - start while in RUN or FLUSH is ignored.
- in_ready = (state==RUN) && (!out_valid || out_ready). A full, stalled output register blocks all inputs, including non-emitting ones. No element is ever dropped.
- Requantize (combinational on the accepted element):
  - s = sext(in_data) + sext(bias[c]), computed in ACC_W+1 bits.
  - r = s >>> shift (arithmetic, floor).
  - ReLU: r<0 gives 0.
  - Saturate: r>32767 gives 32767.
- Pooling (column-pair register colreg, line buffer lb[W_OUT/2] of OUT_W bits):
  - Even w: colreg <= q.
  - Odd w: m = max(colreg, q).
  - Even h: lb[w/2] <= m.
  - Odd h: out_data <= max(lb[w/2], m); out_valid <= 1 on the next edge.
- Latency: 1 cycle from the handshake of element (c, 2ph+1, 2pw+1) to out_valid for pooled element (c, ph, pw).
- Output order: (c, ph, pw) raster order; COUT*H_OUT*W_OUT/4 outputs per run.
- out_valid holds, with out_data stable, until out_ready. Simultaneous out handshake and new emitting input in the same cycle are legal: back-to-back throughput of 1/cycle.
- Channel boundary: colreg and lb need no clearing. Every lb entry is rewritten on each even row before it is read.

Optional Feature:
- Macro CONV1_RQ_ROUND_EN.
  - Defined: when shift>0, add 1<<(shift-1) to s before the shift (round-half-up). Sum is ACC_W+2 bits to avoid overflow.
  - Undefined: pure floor shift as above.
- All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> in_ready=0, out_valid=0, out_data=0, busy=0, done=0. Deassert rst_n -> state IDLE, no outputs.
- Index ramp: bias=0, shift=0, in_data = c*64+h*8+w, out_ready=1 -> 64 outputs, each c*64+(2ph+1)*8+2pw+1 (first 9, last 255). done pulses 1 cycle after the 64th handshake.
- ReLU/bias: all in_data=-100; bias={0,100,150,-5}; shift=0 -> ch0 all 0, ch1 all 0, ch2 all 50, ch3 all 0.
- Shift/saturation, single-value frames:
  - 0x7FFF_0000 with shift 0 -> 32767.
  - 0x7FFF_0000 with shift 16 -> 32767.
  - 0x0001_0000 with shift 4 -> 4096.
  - 0x0000_0017 with shift 2 -> 5 (6 with CONV1_RQ_ROUND_EN).
- Backpressure: ramp as in the index-ramp case, out_ready=0 for 10 cycles at the first output, then toggling 50% -> in_ready low while stalled, out_data stable while out_valid && !out_ready, results identical to the index-ramp case.
- Mid-run reset: pulse rst_n low after 100 input handshakes -> outputs to reset values, no done. Then start a full ramp run -> correct 64 outputs and one done pulse. A start asserted during RUN has no effect.
